// File: rtl/lss_pkg.sv
// rtl/lss_pkg.sv - shared constants, state type and recurrence for the 5-bit LFSR sequence checker
package lss_pkg;

  localparam int LSS_W = 5;
  localparam logic [LSS_W-1:0] SEED = 5'b11111;

  typedef enum logic [1:0] {
    SEARCH,
    SYNC,
    LOCKED
  } lss_state_t;

  // Generator recurrence; the all-zero state maps to itself (lockup).
  function automatic logic [LSS_W-1:0] lss_next(input logic [LSS_W-1:0] p);
    lss_next = {p[4] ^ p[3], p[2] ^ p[4], p[1], p[0], p[4]};
  endfunction

endpackage

// File: rtl/lss5_predict.sv
// rtl/lss5_predict.sv - combinational next-state prediction, match and zero detection
module lss5_predict
  import lss_pkg::*;
(
  input  logic [LSS_W-1:0] in_q,
  input  logic [LSS_W-1:0] prev,
  output logic [LSS_W-1:0] nxt,
  output logic             match,
  output logic             zero
);

  always_comb begin
    nxt   = lss_next(prev);
    match = (in_q == nxt);
    zero  = (in_q == '0);
  end

endmodule

// File: rtl/lss5_checker.sv
// rtl/lss5_checker.sv - locks onto the 5-bit LFSR sequence, counts mismatches,
// flags all-zero lockup and measures the seed-to-seed period
module lss5_checker
  import lss_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [4:0]       in_q,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             lockup,
  output logic [7:0]       period,
  output logic             period_valid
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);
  localparam logic [3:0] LOSS_V = 4'(LOSS_N);

  lss_state_t       state, next_state;
  logic [LSS_W-1:0] prev;
  logic [LSS_W-1:0] nxt;
  logic             match, zero;
  logic [3:0]       match_cnt, miss_cnt;
  logic [7:0]       pcnt;
  logic             armed;
  logic             mis;
  logic             seed_hit;

  lss5_predict u_predict (
    .in_q  (in_q),
    .prev  (prev),
    .nxt   (nxt),
    .match (match),
    .zero  (zero)
  );

  assign mis      = in_valid && (state == LOCKED) && !match;
  assign seed_hit = (in_q == SEED);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= SEARCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SEARCH: if (in_valid && !zero) next_state = SYNC;
      SYNC:   if (in_valid && !zero && match && (match_cnt + 4'd1 == LOCK_V)) next_state = LOCKED;
      LOCKED: if (mis && (miss_cnt + 4'd1 == LOSS_V)) next_state = SEARCH;
      default: next_state = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev         <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      err_pulse    <= 1'b0;
      err_cnt      <= '0;
      lockup       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      pcnt         <= '0;
      armed        <= 1'b0;
    end else begin
      err_pulse    <= mis;
      period_valid <= 1'b0;
      if (in_valid && zero) lockup <= 1'b1;
      // A mismatch in the clearing cycle survives as a count of one.
      if (clr_cnt)                err_cnt <= mis ? CNT_W'(1) : '0;
      else if (mis && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
      if (in_valid) begin
        case (state)
          SEARCH: begin
            if (!zero) begin
              prev      <= in_q;
              match_cnt <= '0;
            end
          end
          SYNC: begin
            if (!zero) begin
              prev      <= in_q;
              match_cnt <= match ? match_cnt + 4'd1 : 4'd0;
            end
          end
          LOCKED: begin
            // Flywheel: a corrupted sample is replaced by the prediction.
            if (match) begin
              prev     <= in_q;
              miss_cnt <= '0;
            end else begin
              prev     <= nxt;
              miss_cnt <= (miss_cnt + 4'd1 == LOSS_V) ? 4'd0 : miss_cnt + 4'd1;
            end
            if (seed_hit) begin
              pcnt  <= 8'd1;
              armed <= 1'b1;
              if (armed) begin
                period       <= pcnt;
                period_valid <= 1'b1;
              end
            end else if (pcnt != 8'hFF) begin
              pcnt <= pcnt + 8'd1;
            end
            if (next_state != LOCKED) armed <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lss5_checker.sv
// tb/tb_lss5_checker.sv - randomized self-checking bench for lss5_checker
module tb_lss5_checker;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_q = '0;
  logic       clr_cnt = 1'b0;

  logic       locked8, err_pulse8, lockup8, period_valid8;
  logic [7:0] err_cnt8, period8;
  logic       locked2, err_pulse2, lockup2, period_valid2;
  logic [1:0] err_cnt2;
  logic [7:0] period2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lss5_checker u8 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_q(in_q), .clr_cnt(clr_cnt),
    .locked(locked8), .err_pulse(err_pulse8), .err_cnt(err_cnt8), .lockup(lockup8),
    .period(period8), .period_valid(period_valid8)
  );

  lss5_checker #(.CNT_W(2)) u2 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_q(in_q), .clr_cnt(clr_cnt),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .lockup(lockup2),
    .period(period2), .period_valid(period_valid2)
  );

  // Reference model state
  bit       m_have, m_locked, m_lockup, m_armed, m_epulse, m_pv;
  bit [4:0] m_prev;
  int       m_run, m_miss, m_vidx, m_last_seed, m_period, m_e8, m_e2;
  bit [4:0] g;

  function automatic bit [4:0] tnext(input bit [4:0] p);
    bit [4:0] n;
    n[0] = p[4];
    n[1] = p[0];
    n[2] = p[1];
    n[3] = p[2] ^ p[4];
    n[4] = p[4] ^ p[3];
    return n;
  endfunction

  task automatic model_reset();
    m_have = 0; m_locked = 0; m_lockup = 0; m_armed = 0; m_epulse = 0; m_pv = 0;
    m_prev = '0; m_run = 0; m_miss = 0; m_vidx = 0; m_last_seed = 0; m_period = 0;
    m_e8 = 0; m_e2 = 0;
  endtask

  task automatic model_step(input bit v, input bit [4:0] q, input bit c);
    bit mis;
    mis = 0;
    m_pv = 0;
    if (v && q == 0) m_lockup = 1;
    if (v && !m_locked) begin
      if (q != 0) begin
        if (!m_have) begin
          m_have = 1; m_prev = q; m_run = 0;
        end else if (q == tnext(m_prev)) begin
          m_run++; m_prev = q;
          if (m_run == 4) begin m_locked = 1; m_miss = 0; m_armed = 0; end
        end else begin
          m_run = 0; m_prev = q;
        end
      end
    end else if (v) begin
      if (q == tnext(m_prev)) begin
        m_prev = q; m_miss = 0;
      end else begin
        mis = 1; m_prev = tnext(m_prev); m_miss++;
      end
      m_vidx++;
      if (q == 5'b11111) begin
        if (m_armed) begin
          m_period = (m_vidx - m_last_seed > 255) ? 255 : m_vidx - m_last_seed;
          m_pv = 1;
        end
        m_armed = 1;
        m_last_seed = m_vidx;
      end
      if (m_miss == 3) begin m_locked = 0; m_have = 0; m_miss = 0; m_armed = 0; end
    end
    if (c) begin
      m_e8 = mis ? 1 : 0; m_e2 = mis ? 1 : 0;
    end else if (mis) begin
      if (m_e8 < 255) m_e8++;
      if (m_e2 < 3) m_e2++;
    end
    m_epulse = mis;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("locked", 32'(locked8), 32'(m_locked));
    chk("err_pulse", 32'(err_pulse8), 32'(m_epulse));
    chk("err_cnt", 32'(err_cnt8), 32'(m_e8));
    chk("lockup", 32'(lockup8), 32'(m_lockup));
    chk("period", 32'(period8), 32'(m_period));
    chk("period_valid", 32'(period_valid8), 32'(m_pv));
    chk("locked_w2", 32'(locked2), 32'(m_locked));
    chk("err_cnt_w2", 32'(err_cnt2), 32'(m_e2));
  endtask

  task automatic tick(input bit v, input bit [4:0] q, input bit c);
    in_valid = v; in_q = q; clr_cnt = c;
    @(posedge clk);
    model_step(v, q, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic clean(input bit v);
    tick(v, g, 1'b0);
    if (v) g = tnext(g);
  endtask

  function automatic bit [4:0] bad_value(input bit [4:0] good);
    bit [4:0] b;
    b = 5'($urandom_range(1, 30));
    while (b == good) b = 5'($urandom_range(1, 30));
    return b;
  endfunction

  task automatic corrupt(input bit [4:0] b, input bit c);
    tick(1'b1, b, c);
    g = tnext(g);
  endtask

  initial begin
    int n_pv;
    model_reset();
    g = 5'b11111;
    repeat (2) @(negedge clk);
    check_all();
    rst_b = 1'b1;

    // Free run from the seed: lock on the 5th sample
    for (int i = 0; i < 5; i++) clean(1'b1);
    chk("lock_at_5", 32'(locked8), 32'd1);
    for (int i = 0; i < 40; i++) clean(1'b1);

    // Single forced corruption
    while (g == 5'b10101) clean(1'b1);
    corrupt(5'b10101, 1'b0);
    chk("single_err_pulse", 32'(err_pulse8), 32'd1);
    clean(1'b1);
    chk("single_err_cnt", 32'(err_cnt8), 32'd1);
    chk("single_still_locked", 32'(locked8), 32'd1);

    // Three consecutive corruptions drop lock, five clean samples relock
    for (int i = 0; i < 3; i++) corrupt(bad_value(g), 1'b0);
    chk("lost_lock", 32'(locked8), 32'd0);
    for (int i = 0; i < 5; i++) clean(1'b1);
    chk("relock", 32'(locked8), 32'd1);

    // Valid toggling while locked, period measured across gaps
    n_pv = 0;
    for (int i = 0; i < 150; i++) begin
      clean(i[0] ? 1'b1 : ($urandom_range(0, 2) == 0));
      if (m_pv) n_pv++;
    end
    chk("period_seen", 32'(n_pv > 0), 32'd1);
    chk("toggle_no_err", 32'(err_cnt8), 32'd4);

    // err_cnt reaches 5, w2 saturates at 3, then clear collides with a mismatch
    corrupt(bad_value(g), 1'b0);
    clean(1'b1);
    chk("err_cnt_5", 32'(err_cnt8), 32'd5);
    chk("err_cnt_w2_sat", 32'(err_cnt2), 32'd3);
    corrupt(bad_value(g), 1'b1);
    chk("clr_with_err", 32'(err_cnt8), 32'd1);
    clean(1'b1);

    // All-zero sample while locked, sticky through clr_cnt
    corrupt(5'b00000, 1'b0);
    chk("lockup_set", 32'(lockup8), 32'd1);
    chk("zero_counts_err", 32'(err_cnt8), 32'd2);
    tick(1'b1, g, 1'b1);
    g = tnext(g);
    chk("clr_only", 32'(err_cnt8), 32'd0);
    chk("lockup_sticky", 32'(lockup8), 32'd1);

    // Random mix of gaps, corruptions and clears
    for (int i = 0; i < 300; i++) begin
      bit v, c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      if (v && $urandom_range(0, 11) == 0) corrupt(($urandom_range(0, 7) == 0) ? 5'b00000 : bad_value(g), c);
      else begin
        tick(v, g, c);
        if (v) g = tnext(g);
      end
    end

    // Asynchronous reset mid-operation, checked before any clock edge
    #2 rst_b = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_b = 1'b1;
    g = 5'b11111;
    for (int i = 0; i < 10; i++) clean(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
